// File: rtl/div32_seq.sv
// ============================================================================
// div32_seq -- iterative 32-bit restoring divider (one quotient bit per cycle)
//
// Computes quotient and remainder of A / B, signed or unsigned, and presents
// them in the HI/LO pair shared with the multiplier: HI = remainder,
// LO = quotient. Signed operation divides magnitudes and then fixes signs.
// The quotient truncates toward zero. The remainder takes the sign of the
// dividend.
//
// Ports
//   CLK          in   1   rising-edge clock
//   RST          in   1   asynchronous active-low reset
//   START        in   1   request, accepted only while idle (BUSY=0)
//   SIGNED       in   1   1 = two's-complement divide, sampled with START
//   A            in  32   dividend, sampled with START
//   B            in  32   divisor, sampled with START
//   HI           out 32   remainder (or A on divide-by-zero), held until next DONE
//   LO           out 32   quotient (or all ones on divide-by-zero), held
//   BUSY         out  1   high from the accept edge until the result edge
//   DONE         out  1   one-cycle pulse when HI/LO update
//   DIVZ         out  1   completed operation had B=0, held until next DONE
//   o_dbg_state  out  2   current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: a request is taken on a rising CLK edge where START=1 and the
// FSM is idle. START seen while busy is dropped. Operands may change freely
// after the accept edge. The result is valid during the single cycle where
// DONE=1 and stays on HI/LO afterwards. START during that DONE cycle is
// accepted at the following edge, which gives back-to-back operation.
//
// Latency: accept at edge k, RUN on edges k+1..k+32, FIX on edge k+33.
// When B=0 the FSM goes straight to FIX, so the result appears at edge k+1.
// ============================================================================
module div32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIVZ,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic [31:0] r_rem;    // partial remainder; always < divisor, so 32 bits suffice
  logic [31:0] r_q;      // dividend shifting out / quotient shifting in
  logic [31:0] r_d;      // divisor magnitude
  logic        r_qneg;
  logic        r_rneg;
  logic        r_dz;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_divz;

  logic        w_accept;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_t;
  logic        w_ge;
  logic [31:0] w_sub;

  assign w_accept = (r_state == S_IDLE) && START;
  assign w_b_zero = (B == 32'd0);

  // Magnitudes. -32'h8000_0000 wraps to itself, which is the correct
  // unsigned magnitude 2^31.
  assign w_a_mag = (SIGNED && A[31]) ? (32'd0 - A) : A;
  assign w_b_mag = (SIGNED && B[31]) ? (32'd0 - B) : B;

  // One restoring step. The trial value is 33 bits wide. Its top bit only
  // takes part in the compare. Whenever the subtraction is taken, the
  // difference is below the divisor, so the low 32 bits are exact.
  assign w_t   = {r_rem, r_q[31]};
  assign w_ge  = (w_t >= {1'b0, r_d});
  assign w_sub = w_t[31:0] - r_d;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next = w_b_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == 5'd31) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt  <= 5'd0;
      r_rem  <= 32'd0;
      r_q    <= 32'd0;
      r_d    <= 32'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_divz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // On divide-by-zero, r_q keeps the raw dividend so FIX can return it
        // unchanged. There is no iteration to disturb it.
        r_q    <= w_b_zero ? A : w_a_mag;
        r_d    <= w_b_mag;
        r_rem  <= 32'd0;
        r_cnt  <= 5'd0;
        r_qneg <= SIGNED & (A[31] ^ B[31]);
        r_rneg <= SIGNED & A[31];
        r_dz   <= w_b_zero;
        r_busy <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_q   <= {r_q[30:0], w_ge};
        r_rem <= w_ge ? w_sub : w_t[31:0];
        r_cnt <= r_cnt + 5'd1;
      end else if (r_state == S_FIX) begin
        if (r_dz) begin
          r_lo <= 32'hFFFF_FFFF;
          r_hi <= r_q;
        end else begin
          r_lo <= r_qneg ? (32'd0 - r_q)   : r_q;
          r_hi <= r_rneg ? (32'd0 - r_rem) : r_rem;
        end
        r_divz <= r_dz;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign HI          = r_hi;
  assign LO          = r_lo;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign DIVZ        = r_divz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div32_seq.sv
// ============================================================================
// tb_div32_seq -- directed self-checking bench for div32_seq
// ============================================================================
module tb_div32_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;
  logic        DIVZ;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {divz, hi, lo}
  logic [64:0] exp_q[$];

  div32_seq dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SIGNED      (SIGNED),
    .A           (A),
    .B           (B),
    .HI          (HI),
    .LO          (LO),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIVZ        (DIVZ),
    .o_dbg_state (o_dbg_state)
  );

  // --------------------------------------------------------------------------
  // Clock and reset
  // --------------------------------------------------------------------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Checking task
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: issue one operation in the current cycle, wait for DONE, then
  // check latency, BUSY duration and the result. If inj >= 0, a stray START
  // with other operands is driven inj cycles after the accept edge.
  // Returns in the DONE cycle, so the next call is back-to-back.
  // --------------------------------------------------------------------------
  task automatic run_op(input string tag,
                        input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ediv,
                        input int elat, input int inj);
    int          cyc;
    int          busy_n;
    logic        got;
    logic [64:0] exp;
    A      = a;
    B      = b;
    SIGNED = s;
    START  = 1'b1;
    exp_q.push_back({ediv, ehi, elo});
    @(posedge CLK); #1;
    START  = 1'b0;
    A      = $urandom;
    B      = $urandom_range(1, 32'h7FFF_FFFF);
    SIGNED = 1'($urandom_range(0, 1));
    check({tag, "_done_low_after_accept"}, 32'(DONE), 32'd0);
    cyc    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && cyc < 40) begin
      if (BUSY) busy_n++;
      if (cyc == inj) begin
        START = 1'b1;
        A     = 32'd7;
        B     = 32'd3;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
      if (DONE) got = 1'b1;
    end
    START = 1'b0;
    exp   = exp_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'(elat));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(elat));
      check({tag, "_busy_low_at_done"}, 32'(BUSY), 32'd0);
      check({tag, "_lo"}, LO, exp[31:0]);
      check({tag, "_hi"}, HI, exp[63:32]);
      check({tag, "_divz"}, 32'(DIVZ), 32'(exp[64]));
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int dones;
    RST    = 1'b0;
    START  = 1'b0;
    SIGNED = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hi",    HI, 32'd0);
    check("rst_lo",    LO, 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    check("rst_done",  32'(DONE), 32'd0);
    check("rst_divz",  32'(DIVZ), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Main function, unsigned and signed, with back-to-back issue
    run_op("u100_7",     32'd100,         32'd7,          1'b0, 32'd2,          32'd14,         1'b0, 33, -1);
    run_op("s_m7_2",     32'hFFFF_FFF9,   32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0, 33, -1);
    run_op("s_7_m2",     32'd7,           32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD,  1'b0, 33, -1);
    run_op("s_m100_m7",  32'hFFFF_FF9C,   32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFFE,  32'd14,         1'b0, 33, -1);
    run_op("u_max_10",   32'hFFFF_FFFF,   32'd10,         1'b0, 32'd5,          32'h1999_9999,  1'b0, 33, -1);
    run_op("s_min_m1",   32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0, 33, -1);
    run_op("u_min_max",  32'h8000_0000,   32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          1'b0, 33, -1);

    // Divide by zero, then a valid op clears DIVZ
    run_op("dz_5",       32'd5,           32'd0,          1'b0, 32'd5,          32'hFFFF_FFFF,  1'b1, 1,  -1);
    run_op("dz_neg",     32'hFFFF_FFF9,   32'd0,          1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFF,  1'b1, 1,  -1);
    run_op("after_dz",   32'd100,         32'd7,          1'b0, 32'd2,          32'd14,         1'b0, 33, -1);

    // Stray START mid-operation is ignored
    run_op("stray_start", 32'd1000,       32'd10,         1'b0, 32'd0,          32'd100,        1'b0, 33, 5);
    @(posedge CLK); #1;
    check("done_one_cycle", 32'(DONE), 32'd0);
    check("stray_not_taken_busy", 32'(BUSY), 32'd0);

    // Reset in the middle of RUN
    @(negedge CLK);
    A      = 32'd1000;
    B      = 32'd10;
    SIGNED = 1'b0;
    START  = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_hi",    HI, 32'd0);
    check("midrst_lo",    LO, 32'd0);
    check("midrst_busy",  32'(BUSY), 32'd0);
    check("midrst_done",  32'(DONE), 32'd0);
    check("midrst_state", 32'(o_dbg_state), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST   = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op("after_rst",  32'd12345,       32'd67,         1'b0, 32'd17,         32'd184,        1'b0, 33, -1);

    @(posedge CLK); #1;
    check("final_done_low", 32'(DONE), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
